float2fix_iter: RTL

Iterative IEEE-754 single-precision to signed fixed-point converter with valid/ready handshakes on both sides. It is the decode direction of the fixed/float datapath. It takes a float word and a binary-point position, shifts the mantissa one bit per cycle, and returns a saturated 32-bit two's-complement fixed-point word with status flags. It sits after float producers, feeding fixed-point consumers, and trades the area of a single-cycle barrel shifter for variable latency.

---
 rtl/float2fix_iter_if.sv | 25 ++
 rtl/float2fix_iter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/float2fix_iter_if.sv
// Handshake bundle for the float-to-fixed converter: float request in, fixed result out.
interface float2fix_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] float_in;
    logic [4:0]  fixpointpos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fix_out;
    logic        overflow;
    logic        inexact;
    logic        invalid;

    // Converter side.
    modport slave (
        input  in_valid, float_in, fixpointpos, out_ready,
        output in_ready, out_valid, fix_out, overflow, inexact, invalid
    );

    // Producer/consumer side.
    modport master (
        output in_valid, float_in, fixpointpos, out_ready,
        input  in_ready, out_valid, fix_out, overflow, inexact, invalid
    );
endinterface

// File: rtl/float2fix_iter.sv
// Iterative IEEE-754 single to saturated signed 32-bit fixed-point converter.
// The mantissa is shifted one bit per cycle instead of through a barrel shifter.
module float2fix_iter (
    input  logic              clk,
    input  logic              rst,
    float2fix_iter_if.slave   bus_io
);

    typedef enum logic [2:0] {StIdle, StDecode, StShift, StPack, StDone} state_e;

    state_e      state_q;
    logic [31:0] float_q;
    logic [4:0]  pos_q;
    logic [31:0] mag_q;
    logic [4:0]  cnt_q;
    logic        left_q;
    logic        sticky_q;
    logic        sat_q;
    logic        nan_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] fix_q;
    logic        ovf_q;
    logic        inx_q;
    logic        inv_q;

    logic [7:0]        exp_w;
    logic [22:0]       frac_w;
    logic signed [9:0] shift_w;
    logic              min_neg_w;

    // Classify the captured operand and derive the signed shift amount.
    always_comb begin
        exp_w     = float_q[30:23];
        frac_w    = float_q[22:0];
        shift_w   = $signed({2'b00, exp_w}) - 10'sd150 + $signed({5'b00000, pos_q});
        // -2^31 is the one magnitude at s=8 that still fits.
        min_neg_w = float_q[31] && (frac_w == 23'd0) && (shift_w == 10'sd8);
    end

    // Control FSM with the shift datapath and registered results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            float_q     <= 32'd0;
            pos_q       <= 5'd0;
            mag_q       <= 32'd0;
            cnt_q       <= 5'd0;
            left_q      <= 1'b0;
            sticky_q    <= 1'b0;
            sat_q       <= 1'b0;
            nan_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            fix_q       <= 32'd0;
            ovf_q       <= 1'b0;
            inx_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        float_q    <= bus_io.float_in;
                        pos_q      <= bus_io.fixpointpos;
                        in_ready_q <= 1'b0;
                        state_q    <= StDecode;
                    end
                end
                StDecode: begin
                    mag_q    <= 32'd0;
                    sticky_q <= 1'b0;
                    sat_q    <= 1'b0;
                    nan_q    <= 1'b0;
                    state_q  <= StPack;
                    if (exp_w == 8'hff) begin
                        if (frac_w != 23'd0) nan_q <= 1'b1;
                        else                 sat_q <= 1'b1;
                    end else if (exp_w == 8'h00) begin
                        sticky_q <= |frac_w;
                    end else if (shift_w >= 10'sd8) begin
                        if (min_neg_w) mag_q <= 32'h8000_0000;
                        else           sat_q <= 1'b1;
                    end else if (shift_w < -10'sd24) begin
                        sticky_q <= 1'b1;
                    end else if (shift_w >= 10'sd0) begin
                        mag_q  <= {8'd0, 1'b1, frac_w};
                        left_q <= 1'b1;
                        cnt_q  <= shift_w[4:0];
                        if (shift_w != 10'sd0) state_q <= StShift;
                    end else begin
                        mag_q   <= {8'd0, 1'b1, frac_w};
                        left_q  <= 1'b0;
                        cnt_q   <= 5'd0 - shift_w[4:0];
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (left_q) begin
                        mag_q <= mag_q << 1;
                    end else begin
                        mag_q    <= mag_q >> 1;
                        sticky_q <= sticky_q | mag_q[0];
                    end
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) state_q <= StPack;
                end
                StPack: begin
                    if (nan_q) begin
                        fix_q <= 32'd0;
                    end else if (sat_q) begin
                        fix_q <= float_q[31] ? 32'h8000_0000 : 32'h7fff_ffff;
                    end else begin
                        fix_q <= float_q[31] ? (32'd0 - mag_q) : mag_q;
                    end
                    ovf_q       <= sat_q;
                    inv_q       <= nan_q;
                    inx_q       <= sticky_q && !nan_q && !sat_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (bus_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.fix_out   = fix_q;
    assign bus_io.overflow  = ovf_q;
    assign bus_io.inexact   = inx_q;
    assign bus_io.invalid   = inv_q;

endmodule
